// File: rtl/udm_uart_rx.sv
// -----------------------------------------------------------------------------
// udm_uart_rx
// UART 8N1 receiver feeding the UDM debug bus master. The raw pin is
// synchronized, a falling edge seen while idle starts a frame, the start bit is
// confirmed at its centre, and data/stop bits are sampled at their centres.
// The bit period is a runtime input, latched once per frame at start detect.
//
// Ports:
//   clk_i          system clock
//   arst_i         asynchronous reset, active-high
//   rx_i           raw serial line (idle high, asynchronous to clk_i)
//   bitperiod_i    clock cycles per bit (clamped up to MIN_BITPERIOD)
//   rx_data_o      last correctly received byte
//   rx_done_tick_o one-cycle strobe, rx_data_o valid on it
//   frame_err_o    one-cycle strobe on a bad (low) stop bit
//   busy_o         high while a frame is in progress
// -----------------------------------------------------------------------------
module udm_uart_rx #(
  parameter int unsigned MIN_BITPERIOD = 8
) (
  input  logic        clk_i,
  input  logic        arst_i,
  input  logic        rx_i,
  input  logic [31:0] bitperiod_i,
  output logic [7:0]  rx_data_o,
  output logic        rx_done_tick_o,
  output logic        frame_err_o,
  output logic        busy_o
);

  localparam logic [31:0] MIN_BP = 32'(MIN_BITPERIOD);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t      state_q;
  logic        rx_meta_q;
  logic        rx_s_q;
  logic        rx_s_d_q;
  logic [31:0] bp_q;
  logic [31:0] cnt_q;
  logic [2:0]  idx_q;
  logic [7:0]  shift_q;
  logic [7:0]  data_q;
  logic        tick_q;
  logic        err_q;

  logic [31:0] bp_d;
  logic        start_det;
  logic        half_done;
  logic        bit_done;

  function automatic logic [31:0] clamp_bp(input logic [31:0] v);
    return (v < MIN_BP) ? MIN_BP : v;
  endfunction

  assign bp_d      = clamp_bp(bitperiod_i);
  // Falling edge only: a line parked low never looks like a fresh start.
  assign start_det = (state_q == IDLE) && rx_s_d_q && !rx_s_q;
  assign half_done = (cnt_q == ((bp_q >> 1) - 32'd1));
  assign bit_done  = (cnt_q == (bp_q - 32'd1));

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q   <= IDLE;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_s_d_q  <= 1'b1;
      bp_q      <= MIN_BP;
      cnt_q     <= 32'd0;
      idx_q     <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      tick_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
      rx_s_d_q  <= rx_s_q;
      tick_q    <= 1'b0;
      err_q     <= 1'b0;

      case (state_q)
        IDLE: begin
          if (start_det) begin
            bp_q    <= bp_d;
            cnt_q   <= 32'd0;
            idx_q   <= 3'd0;
            state_q <= START;
          end
        end

        START: begin
          if (half_done) begin
            cnt_q   <= 32'd0;
            // Line back high at mid start bit means it was a glitch.
            state_q <= rx_s_q ? IDLE : DATA;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end

        DATA: begin
          if (bit_done) begin
            cnt_q   <= 32'd0;
            shift_q <= {rx_s_q, shift_q[7:1]};
            if (idx_q == 3'd7) begin
              state_q <= STOP;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end

        STOP: begin
          if (bit_done) begin
            cnt_q   <= 32'd0;
            // Returning to IDLE at mid stop bit leaves half a bit of slack
            // for a back-to-back start edge.
            state_q <= IDLE;
            if (rx_s_q) begin
              data_q <= shift_q;
              tick_q <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign rx_data_o      = data_q;
  assign rx_done_tick_o = tick_q;
  assign frame_err_o    = err_q;
  assign busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_udm_uart_rx.sv
module tb_udm_uart_rx;

  logic        clk_i;
  logic        arst_i;
  logic        rx_i;
  logic [31:0] bitperiod_i;
  logic [7:0]  rx_data_o;
  logic        rx_done_tick_o;
  logic        frame_err_o;
  logic        busy_o;

  udm_uart_rx #(.MIN_BITPERIOD(8)) dut (
    .clk_i          (clk_i),
    .arst_i         (arst_i),
    .rx_i           (rx_i),
    .bitperiod_i    (bitperiod_i),
    .rx_data_o      (rx_data_o),
    .rx_done_tick_o (rx_done_tick_o),
    .frame_err_o    (frame_err_o),
    .busy_o         (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    bit         err;
    logic [7:0] data;
  } exp_t;

  exp_t        sb_q[$];
  int          vectors;
  int          miscompares;
  logic [7:0]  last_good;
  time         fall_t;
  time         tick_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every strobe must match the oldest expected frame outcome.
  always @(negedge clk_i) begin
    if (!arst_i && (rx_done_tick_o || frame_err_o)) begin
      exp_t e;
      if (rx_done_tick_o) tick_t = $time;
      chk("strobe_exclusive", {31'd0, rx_done_tick_o & frame_err_o}, 32'd0);
      if (sb_q.size() == 0) begin
        chk("unexpected_strobe", {30'd0, rx_done_tick_o, frame_err_o}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("strobe_kind", {31'd0, frame_err_o}, {31'd0, e.err});
        chk("rx_data", {24'd0, rx_data_o}, {24'd0, e.data});
        if (rx_done_tick_o) chk("busy_at_tick", {31'd0, busy_o}, 32'd0);
      end
    end
  end

  // Drives one 8N1 frame at bp cycles per bit. Leaves rx_i at the stop level.
  // chg_bit: data bit at which bitperiod_i is rewritten to chg_val.
  // rst_bit: data bit at which the frame is aborted by reset.
  task automatic send_frame(input logic [7:0] b, input int bp, input bit stop_ok,
                            input int chg_bit, input logic [31:0] chg_val,
                            input int rst_bit);
    exp_t e;
    if (rst_bit < 0) begin
      e.err  = !stop_ok;
      e.data = stop_ok ? b : last_good;
      if (stop_ok) last_good = b;
      sb_q.push_back(e);
    end
    rx_i   = 1'b0;
    fall_t = $time;
    repeat (bp) @(negedge clk_i);
    for (int k = 0; k < 8; k++) begin
      if (k == chg_bit) bitperiod_i = chg_val;
      if (k == rst_bit) begin
        arst_i = 1'b1;
        rx_i   = 1'b1;
        #1;
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_tick", {31'd0, rx_done_tick_o}, 32'd0);
        chk("rst_ferr", {31'd0, frame_err_o}, 32'd0);
        chk("rst_data", {24'd0, rx_data_o}, 32'd0);
        last_good = 8'h00;
        repeat (5) @(negedge clk_i);
        arst_i = 1'b0;
        repeat (2 * bp) @(negedge clk_i);
        return;
      end
      rx_i = b[k];
      repeat (bp) @(negedge clk_i);
    end
    rx_i = stop_ok;
    repeat (bp) @(negedge clk_i);
  endtask

  initial begin
    int lat;
    vectors     = 0;
    miscompares = 0;
    last_good   = 8'h00;
    tick_t      = 0;
    fall_t      = 0;
    arst_i      = 1'b1;
    rx_i        = 1'b1;
    bitperiod_i = 32'd868;
    repeat (3) @(negedge clk_i);
    chk("reset_data", {24'd0, rx_data_o}, 32'd0);
    chk("reset_tick", {31'd0, rx_done_tick_o}, 32'd0);
    chk("reset_ferr", {31'd0, frame_err_o}, 32'd0);
    chk("reset_busy", {31'd0, busy_o}, 32'd0);
    arst_i = 1'b0;
    repeat (5) @(negedge clk_i);

    // 0x55 at 868 cycles per bit, with end-to-end latency check.
    send_frame(8'h55, 868, 1'b1, -1, 32'd0, -1);
    repeat (20) @(negedge clk_i);
    lat = int'((tick_t - fall_t) / 10);
    vectors++;
    if (tick_t < fall_t || lat < 8248 || lat > 8250) begin
      miscompares++;
      $display("FAIL latency_0x55: got %0d cycles, expected 8248..8250", lat);
    end

    // Back-to-back frames, single stop bit.
    bitperiod_i = 32'd16;
    send_frame(8'h00, 16, 1'b1, -1, 32'd0, -1);
    send_frame(8'hFF, 16, 1'b1, -1, 32'd0, -1);
    send_frame(8'hA3, 16, 1'b1, -1, 32'd0, -1);
    repeat (40) @(negedge clk_i);

    // Start-bit glitch at 868: busy until about cycle 437, then idle.
    bitperiod_i = 32'd868;
    rx_i = 1'b0;
    repeat (100) @(negedge clk_i);
    rx_i = 1'b1;
    repeat (330) @(negedge clk_i);
    chk("glitch_busy_high", {31'd0, busy_o}, 32'd1);
    repeat (15) @(negedge clk_i);
    chk("glitch_busy_low", {31'd0, busy_o}, 32'd0);
    repeat (20) @(negedge clk_i);

    // Framing error then line parked low: no retrigger until a new fall.
    bitperiod_i = 32'd64;
    send_frame(8'h3C, 64, 1'b0, -1, 32'd0, -1);
    repeat (5000) @(negedge clk_i);
    chk("low_line_no_start", {31'd0, busy_o}, 32'd0);
    rx_i = 1'b1;
    repeat (64) @(negedge clk_i);
    send_frame(8'h12, 64, 1'b1, -1, 32'd0, -1);
    repeat (100) @(negedge clk_i);

    // Bit period changed mid-frame applies only to the next frame.
    bitperiod_i = 32'd868;
    send_frame(8'h96, 868, 1'b1, 3, 32'd434, -1);
    send_frame(8'h69, 434, 1'b1, -1, 32'd0, -1);
    repeat (50) @(negedge clk_i);

    // Clamp: requested 2, line runs at 8.
    bitperiod_i = 32'd2;
    send_frame(8'hB4, 8, 1'b1, -1, 32'd0, -1);
    send_frame(8'h4B, 8, 1'b1, -1, 32'd0, -1);
    repeat (20) @(negedge clk_i);

    // Reset during data bit 4, then a clean 0xC6.
    bitperiod_i = 32'd64;
    send_frame(8'h77, 64, 1'b1, -1, 32'd0, 4);
    send_frame(8'hC6, 64, 1'b1, -1, 32'd0, -1);
    repeat (100) @(negedge clk_i);

    // Random frames: random byte, bit period, gap, occasional bad stop.
    for (int i = 0; i < 30; i++) begin
      int         bp;
      logic [7:0] b;
      bit         ok;
      bp = int'($urandom_range(8, 40));
      b  = 8'($urandom);
      ok = ($urandom_range(0, 7) != 0);
      bitperiod_i = 32'(bp);
      send_frame(b, bp, ok, -1, 32'd0, -1);
      if (!ok) begin
        rx_i = 1'b1;
        repeat (bp) @(negedge clk_i);
      end
      repeat ($urandom_range(0, 10)) @(negedge clk_i);
    end

    repeat (200) @(negedge clk_i);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/udm_uart_rx.md
# udm_uart_rx

UART receiver that converts the serial `rx_i` line of the kerygma SoC into bytes for the UDM debug bus master. It sits directly upstream of the UDM protocol decoder: it synchronizes the pin, detects and validates start bits, and samples 8N1 frames at bit centres. On each good frame it emits a one-cycle byte strobe. The bit period comes from a runtime input, so one netlist supports every divider the team uses (868 clocks per bit = 115200 baud at 100 MHz).

## Interface
- `MIN_BITPERIOD`, default 8: smallest accepted clocks-per-bit; smaller `bitperiod_i` values are clamped to this.
- `clk_i`  in  1  system clock.
- `arst_i`  in  1  asynchronous reset, active-high.
- `rx_i`  in  1  raw serial line, idle high, asynchronous to `clk_i`.
- `bitperiod_i`  in  32  clock cycles per bit.
- `rx_data_o`  out  8  last correctly received byte.
- `rx_done_tick_o`  out  1  one-cycle strobe; `rx_data_o` is valid on it.
- `frame_err_o`  out  1  one-cycle strobe on a bad stop bit.
- `busy_o`  out  1  high while a frame is in progress (any state except IDLE).

## Operation
- Input sync: two flops on `rx_i` produce `rx_s`. A third flop holds `rx_s_d` for edge detection. All three reset to 1.
- Start detect: only in IDLE, and only on a falling edge (`rx_s_d`=1, `rx_s`=0). A line held low never retriggers a start.
- On start detect:
  - Latch `bp = max(bitperiod_i, MIN_BITPERIOD)`. Changes to `bitperiod_i` mid-frame are ignored.
  - Clear the cycle counter and the bit index, then go to START.
- START: count to `(bp>>1)-1`, then sample `rx_s`.
  - 0 → go to DATA and clear the counter.
  - 1 → glitch; return to IDLE with no strobe.
- DATA: count to `bp-1`, then sample `rx_s` into the shift register, LSB first.
  - After bit index 7, go to STOP; otherwise increment the index.
- STOP: count to `bp-1`, then sample.
  - 1 → load the shift register into `rx_data_o`, pulse `rx_done_tick_o`.
  - 0 → pulse `frame_err_o`; `rx_data_o` is unchanged.
  - Either way, return to IDLE the next cycle.
- Counter width is 32 bits, compared with equality. `bp` is never below `MIN_BITPERIOD`, so the counter cannot wrap.
- A reset mid-frame aborts immediately. No strobe is emitted for the aborted frame.

## Timing
- Reset values:
  - State IDLE; `rx_data_o`=8'h00.
  - `rx_done_tick_o`=0, `frame_err_o`=0, `busy_o`=0.
  - Sync flops = 1.
- A falling edge of `rx_i` is seen in IDLE 2–3 cycles later, depending on sampling phase and metastability resolution.
- `busy_o` rises on the cycle after start detect.
- Sample points, in cycles after start detect:
  - Start bit: `bp>>1`.
  - Data bit k: `(bp>>1) + (k+1)·bp`.
  - Stop bit: `(bp>>1) + 9·bp`.
- The strobe is registered: it is high the cycle after the stop sample. `busy_o` is low in that same cycle.
- `rx_data_o` updates in the same cycle as `rx_done_tick_o` and holds until the next good frame.
- Back-to-back frames: the state is IDLE from the half-stop-bit point onward. A start edge at a nominal one-stop-bit spacing is therefore caught with about `bp/2` cycles of margin.
- Strobes never overlap. There is at most one strobe per frame.

## Test plan
- `bitperiod_i`=868; send 0x55 in 8N1 → exactly one `rx_done_tick_o` with `rx_data_o`=0x55, about 8249 cycles after the edge; `frame_err_o` never asserted.
- Back-to-back 0x00, 0xFF, 0xA3, each with a single stop bit → three ticks carrying 0x00, 0xFF, 0xA3 in order, with no errors.
- Glitch: `rx_i` low for 100 cycles, then high (`bp`=868) → returns to IDLE; no tick, no error; `busy_o` falls at about cycle 434.
- Framing error: 0x3C with the stop bit low, then the line held low for 5000 cycles → one `frame_err_o` pulse, `rx_data_o` keeps its previous value, and no new start until the line goes high and falls again. A following good 0x12 → tick with 0x12.
- Configuration change:
  - Set `bitperiod_i` from 868 to 434 mid-frame → the current byte is still decoded correctly at 868.
  - The next frame is decoded at 434.
  - `bitperiod_i`=2 → clamped to 8; a frame sent at 8 cycles per bit decodes correctly.
- Reset: assert `arst_i` during data bit 4 → all outputs go to reset values immediately, and no tick occurs for that frame. After release, the next full frame 0xC6 decodes correctly.
